// File: rtl/spawn_scheduler.sv
// -----------------------------------------------------------------------------
// spawn_scheduler
//
// Purpose:
//    Sequences alien spawn requests into event_core while a level is in play.
//    On start it derives a level-scaled spawn interval (in 10 Hz ticks) and a
//    per-level spawn quota, then repeatedly waits out the interval, holds off
//    while the field is at object capacity, and hands each spawn over with a
//    valid/ready handshake until the quota is exhausted. abort returns the
//    block to IDLE at any time.
//
// Optional feature macro:
//    SPAWN_JITTER_EN - adds input jitter[1:0]; every timer reload becomes
//                      interval + jitter, saturating at 2^CNT_W - 1.
//
// Ports:
//    clk            in   system clock
//    rst            in   asynchronous active-high reset
//    start          in   one-cycle pulse, latches level and begins a sequence
//    abort          in   one-cycle pulse, returns to IDLE (wins over start)
//    level          in   current level, sampled on start
//    tick           in   one-cycle 10 Hz strobe, synchronous to clk
//    object_count   in   live objects reported by event_core
//    spawn_ready    in   event_core accepts a spawn this cycle
//    jitter         in   (SPAWN_JITTER_EN only) extra ticks added on reload
//    spawn_valid    out  spawn request pending (state REQ)
//    spawn_done     out  quota exhausted (state DONE)
//    busy           out  high in WAIT, HOLD and REQ
//    spawned_count  out  handshakes completed in the current sequence
// -----------------------------------------------------------------------------
module spawn_scheduler #(
   parameter int LEVEL_SIZE    = 4,
   parameter int CNT_W         = 8,
   parameter int BASE_INTERVAL = 50,
   parameter int INTERVAL_STEP = 5,
   parameter int MIN_INTERVAL  = 10,
   parameter int BASE_QUOTA    = 6,
   parameter int QUOTA_STEP    = 2,
   parameter int MAX_OBJECTS   = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   input  logic [LEVEL_SIZE-1:0] level,
   input  logic                  tick,
   input  logic [3:0]            object_count,
   input  logic                  spawn_ready,
`ifdef SPAWN_JITTER_EN
   input  logic [1:0]            jitter,
`endif
   output logic                  spawn_valid,
   output logic                  spawn_done,
   output logic                  busy,
   output logic [CNT_W-1:0]      spawned_count
);

   // Start arithmetic is carried out wide enough that step*level cannot wrap.
   localparam int CALC_W = CNT_W + LEVEL_SIZE;

   localparam logic [CALC_W-1:0] BASE_I_C  = CALC_W'(BASE_INTERVAL);
   localparam logic [CALC_W-1:0] STEP_I_C  = CALC_W'(INTERVAL_STEP);
   localparam logic [CALC_W-1:0] MIN_I_C   = CALC_W'(MIN_INTERVAL);
   localparam logic [CALC_W-1:0] BASE_Q_C  = CALC_W'(BASE_QUOTA);
   localparam logic [CALC_W-1:0] STEP_Q_C  = CALC_W'(QUOTA_STEP);
   localparam logic [CALC_W-1:0] CNT_MAX_C = CALC_W'((2 ** CNT_W) - 1);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_WAIT = 3'd1,
      ST_HOLD = 3'd2,
      ST_REQ  = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   // interval = max(MIN, BASE - STEP*level); an underflowing difference clamps
   // to MIN as well. The result is also capped to the counter range.
   function automatic logic [CNT_W-1:0] calc_interval(input logic [LEVEL_SIZE-1:0] lvl);
      logic [CALC_W-1:0] lvl_w;
      logic [CALC_W-1:0] reduction;
      logic [CALC_W-1:0] diff;
      logic [CALC_W-1:0] res;
      lvl_w     = {{CNT_W{1'b0}}, lvl};
      reduction = STEP_I_C * lvl_w;
      diff      = BASE_I_C - reduction;
      res       = ((BASE_I_C > reduction) && (diff > MIN_I_C)) ? diff : MIN_I_C;
      res       = (res > CNT_MAX_C) ? CNT_MAX_C : res;
      return res[CNT_W-1:0];
   endfunction

   // quota = min(2^CNT_W - 1, BASE + STEP*level).
   function automatic logic [CNT_W-1:0] calc_quota(input logic [LEVEL_SIZE-1:0] lvl);
      logic [CALC_W-1:0] lvl_w;
      logic [CALC_W-1:0] sum;
      lvl_w = {{CNT_W{1'b0}}, lvl};
      sum   = BASE_Q_C + (STEP_Q_C * lvl_w);
      sum   = (sum > CNT_MAX_C) ? CNT_MAX_C : sum;
      return sum[CNT_W-1:0];
   endfunction

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   timer_q, timer_d;
   logic [CNT_W-1:0]   interval_q, interval_d;
   logic [CNT_W-1:0]   quota_q, quota_d;
   logic [CNT_W-1:0]   spawned_count_q, spawned_count_d;
   logic               spawn_valid_q, spawn_valid_d;
   logic               spawn_done_q, spawn_done_d;
   logic               busy_q, busy_d;

   logic [CNT_W-1:0]   start_interval;
   logic [CNT_W-1:0]   start_quota;
   logic [CNT_W-1:0]   start_reload;
   logic [CNT_W-1:0]   next_reload;
   logic [CNT_W-1:0]   count_inc;
   logic               at_capacity;

`ifdef SPAWN_JITTER_EN
   // Adds the jitter ticks to a reload value, saturating at the counter max.
   function automatic logic [CNT_W-1:0] reload_value(input logic [CNT_W-1:0] base,
                                                     input logic [1:0]       jit);
      logic [CNT_W:0] sum;
      sum = {1'b0, base} + {{(CNT_W-1){1'b0}}, jit};
      return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
   endfunction
`else
   // Without jitter the timer reloads the exact interval.
   function automatic logic [CNT_W-1:0] reload_value(input logic [CNT_W-1:0] base,
                                                     input logic [1:0]       jit);
      logic [1:0] unused_jit;
      unused_jit = jit;
      return base;
   endfunction
`endif

   // Derived values used by the next-state logic.
   always_comb begin
      start_interval = calc_interval(level);
      start_quota    = calc_quota(level);
`ifdef SPAWN_JITTER_EN
      start_reload   = reload_value(start_interval, jitter);
      next_reload    = reload_value(interval_q, jitter);
`else
      start_reload   = reload_value(start_interval, 2'b00);
      next_reload    = reload_value(interval_q, 2'b00);
`endif
      count_inc      = spawned_count_q + CNT_W'(1);
      at_capacity    = (32'(object_count) >= MAX_OBJECTS);
   end

   // Next-state, timer, latched-parameter and counter logic.
   always_comb begin
      state_d         = state_q;
      timer_d         = timer_q;
      interval_d      = interval_q;
      quota_d         = quota_q;
      spawned_count_d = spawned_count_q;

      if (abort) begin
         // spawned_count deliberately holds so the aborted progress stays visible
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  interval_d      = start_interval;
                  quota_d         = start_quota;
                  timer_d         = start_reload;
                  spawned_count_d = {CNT_W{1'b0}};
                  state_d         = ST_WAIT;
               end else begin
                  state_d = state_q;
               end
            end
            ST_WAIT: begin
               if (tick) begin
                  if (timer_q == CNT_W'(1)) begin
                     state_d = at_capacity ? ST_HOLD : ST_REQ;
                  end else begin
                     timer_d = timer_q - CNT_W'(1);
                  end
               end else begin
                  state_d = ST_WAIT;
               end
            end
            ST_HOLD: begin
               // ticks are ignored here; only capacity matters
               if (!at_capacity) begin
                  state_d = ST_REQ;
               end else begin
                  state_d = ST_HOLD;
               end
            end
            ST_REQ: begin
               // the timer is frozen and any coincident tick is discarded
               if (spawn_ready) begin
                  spawned_count_d = count_inc;
                  if (count_inc == quota_q) begin
                     state_d = ST_DONE;
                  end else begin
                     timer_d = next_reload;
                     state_d = ST_WAIT;
                  end
               end else begin
                  state_d = ST_REQ;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // Output decode from the next state so the flopped outputs track state_q.
   always_comb begin
      spawn_valid_d = (state_d == ST_REQ);
      spawn_done_d  = (state_d == ST_DONE);
      busy_d        = (state_d == ST_WAIT) || (state_d == ST_HOLD) || (state_d == ST_REQ);
   end

   // State, datapath and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= ST_IDLE;
         timer_q         <= {CNT_W{1'b0}};
         interval_q      <= {CNT_W{1'b0}};
         quota_q         <= {CNT_W{1'b0}};
         spawned_count_q <= {CNT_W{1'b0}};
         spawn_valid_q   <= 1'b0;
         spawn_done_q    <= 1'b0;
         busy_q          <= 1'b0;
      end else begin
         state_q         <= state_d;
         timer_q         <= timer_d;
         interval_q      <= interval_d;
         quota_q         <= quota_d;
         spawned_count_q <= spawned_count_d;
         spawn_valid_q   <= spawn_valid_d;
         spawn_done_q    <= spawn_done_d;
         busy_q          <= busy_d;
      end
   end

   assign spawn_valid   = spawn_valid_q;
   assign spawn_done    = spawn_done_q;
   assign busy          = busy_q;
   assign spawned_count = spawned_count_q;

endmodule

// File: tb/tb_spawn_scheduler.sv
// -----------------------------------------------------------------------------
// tb_spawn_scheduler
//
// Directed bench for spawn_scheduler: a table of {level, interval, quota}
// rows run to completion, followed by hand-written sequences for capacity
// hold, ready stall, abort, ignored start, asynchronous reset and (when
// SPAWN_JITTER_EN is defined) jittered spacing.
// -----------------------------------------------------------------------------
module tb_spawn_scheduler;

   localparam int TP = 10;   // clocks per tick

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       abort;
   logic [3:0] level;
   logic       tick;
   logic [3:0] object_count;
   logic       spawn_ready;
   logic       spawn_valid;
   logic       spawn_done;
   logic       busy;
   logic [7:0] spawned_count;
`ifdef SPAWN_JITTER_EN
   logic [1:0] jitter;
`endif

   int  n_tests = 0;
   int  n_fail  = 0;
   bit  tick_en;
   int  tick_div;
   bit  tick_at_edge;

   typedef struct {
      logic [3:0] level;
      int         interval;
      int         quota;
   } vec_t;

   vec_t vecs[4];

   spawn_scheduler dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .abort         (abort),
      .level         (level),
      .tick          (tick),
      .object_count  (object_count),
      .spawn_ready   (spawn_ready),
`ifdef SPAWN_JITTER_EN
      .jitter        (jitter),
`endif
      .spawn_valid   (spawn_valid),
      .spawn_done    (spawn_done),
      .busy          (busy),
      .spawned_count (spawned_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // One clock: drive the auto tick, take the edge, sample 1 time unit later.
   task automatic run_cycle();
      if (tick_en) tick = (tick_div == TP - 1);
      @(posedge clk);
      tick_at_edge = tick;
      #1;
      tick = 1'b0;
      if (tick_en) tick_div = (tick_div == TP - 1) ? 0 : tick_div + 1;
   endtask

   task automatic do_start(input logic [3:0] lvl, input string nm);
      level    = lvl;
      start    = 1'b1;
      tick_en  = 1'b1;
      tick_div = 0;
      run_cycle();
      start = 1'b0;
      check({nm, "_busy"}, busy, 1);
      check({nm, "_done"}, spawn_done, 0);
      check({nm, "_count"}, spawned_count, 0);
   endtask

   // Waits for spawn_valid to rise; it must rise on the edge right after the
   // exp_ticks-th tick counted from here.
   task automatic wait_rise(input int exp_ticks, input string nm);
      int cnt;
      bit seen;
      cnt  = 0;
      seen = 1'b0;
      for (int c = 0; c < exp_ticks * TP + 4 * TP && !seen; c++) begin
         run_cycle();
         if (tick_at_edge) cnt++;
         if (spawn_valid) seen = 1'b1;
      end
      check({nm, "_seen"}, seen, 1);
      check({nm, "_ticks"}, cnt, exp_ticks);
      check({nm, "_edge_tick"}, tick_at_edge, 1);
   endtask

   // Handshake edge with spawn_ready already high; k is the zero-based spawn.
   task automatic handshake(input int k, input int quota, input string nm);
      run_cycle();
      check({nm, "_count"}, spawned_count, k + 1);
      check({nm, "_valid_low"}, spawn_valid, 0);
      if (k + 1 == quota) begin
         check({nm, "_done"}, spawn_done, 1);
         check({nm, "_busy"}, busy, 0);
      end else begin
         check({nm, "_done"}, spawn_done, 0);
         check({nm, "_busy"}, busy, 1);
      end
   endtask

   initial begin
      int  cnt;
      bit  flag;
      string nm;

      vecs[0] = '{level: 4'd0,  interval: 50, quota: 6};
      vecs[1] = '{level: 4'd9,  interval: 10, quota: 24};
      vecs[2] = '{level: 4'd8,  interval: 10, quota: 22};
      vecs[3] = '{level: 4'd15, interval: 10, quota: 36};

      rst          = 1'b1;
      start        = 1'b0;
      abort        = 1'b0;
      level        = 4'd0;
      tick         = 1'b0;
      object_count = 4'd0;
      spawn_ready  = 1'b0;
      tick_en      = 1'b0;
      tick_div     = 0;
`ifdef SPAWN_JITTER_EN
      jitter       = 2'd0;
`endif
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", spawn_valid, 0);
      check("rst_done", spawn_done, 0);
      check("rst_busy", busy, 0);
      check("rst_count", spawned_count, 0);
      rst = 1'b0;
      run_cycle();
      check("idle_busy", busy, 0);

      // Table rows: full sequences, each restarted from DONE after the first.
      spawn_ready = 1'b1;
      for (int v = 0; v < 4; v++) begin
         nm = $sformatf("lvl%0d", vecs[v].level);
         do_start(vecs[v].level, {nm, "_start"});
         for (int k = 0; k < vecs[v].quota; k++) begin
            wait_rise(vecs[v].interval, $sformatf("%s_rise%0d", nm, k));
            handshake(k, vecs[v].quota, $sformatf("%s_hs%0d", nm, k));
         end
      end

      // Capacity hold: timer expires with object_count at MAX_OBJECTS.
      spawn_ready  = 1'b0;
      object_count = 4'd8;
      do_start(4'd0, "hold_start");
      cnt = 0;
      for (int c = 0; c < 60 * TP && cnt < 50; c++) begin
         run_cycle();
         if (tick_at_edge) cnt++;
      end
      check("hold_ticks", cnt, 50);
      check("hold_valid", spawn_valid, 0);
      check("hold_busy", busy, 1);
      flag = 1'b0;
      for (int c = 0; c < 30 * TP; c++) begin
         run_cycle();
         if (spawn_valid || !busy) flag = 1'b1;
      end
      check("hold_30ticks_stable", flag, 0);
      object_count = 4'd7;
      run_cycle();
      check("hold_release_valid", spawn_valid, 1);
      object_count = 4'd0;

      // Ready stall: 20 cycles with 3 ticks, then handshake coincident with a tick.
      tick_en = 1'b0;
      flag    = 1'b0;
      for (int c = 0; c < 20; c++) begin
         tick = (c == 3) || (c == 9) || (c == 15);
         run_cycle();
         if (!spawn_valid) flag = 1'b1;
      end
      check("stall_valid_dropped", flag, 0);
      check("stall_count", spawned_count, 0);
      tick        = 1'b1;
      spawn_ready = 1'b1;
      run_cycle();
      check("stall_hs_count", spawned_count, 1);
      check("stall_hs_valid", spawn_valid, 0);
      check("stall_hs_busy", busy, 1);
      tick_en  = 1'b1;
      tick_div = 0;
      wait_rise(50, "stall_next");
      handshake(1, 6, "stall_hs2");

      // Abort in WAIT after two spawns, with an ignored start in between.
      abort = 1'b1;
      run_cycle();
      abort = 1'b0;
      do_start(4'd9, "ab_start");
      wait_rise(10, "ab_rise0");
      handshake(0, 24, "ab_hs0");
      level = 4'd0;
      start = 1'b1;
      run_cycle();
      start = 1'b0;
      check("busy_start_count", spawned_count, 1);
      check("busy_start_busy", busy, 1);
      wait_rise(10, "ab_rise1");
      handshake(1, 24, "ab_hs1");
      repeat (5) run_cycle();
      abort = 1'b1;
      run_cycle();
      abort = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_valid", spawn_valid, 0);
      check("abort_done", spawn_done, 0);
      check("abort_count", spawned_count, 2);
      start = 1'b1;
      abort = 1'b1;
      run_cycle();
      start = 1'b0;
      abort = 1'b0;
      check("start_abort_busy", busy, 0);
      check("start_abort_count", spawned_count, 2);
      run_cycle();
      check("start_abort_stay_idle", busy, 0);

      // Asynchronous reset between edges while in REQ.
      do_start(4'd9, "rst_seq_start");
      wait_rise(10, "rst_rise0");
      handshake(0, 24, "rst_hs0");
      spawn_ready = 1'b0;
      wait_rise(10, "rst_rise1");
      check("pre_rst_count", spawned_count, 1);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_valid", spawn_valid, 0);
      check("async_rst_busy", busy, 0);
      check("async_rst_done", spawn_done, 0);
      check("async_rst_count", spawned_count, 0);
      #1;
      rst = 1'b0;
      run_cycle();
      check("post_rst_busy", busy, 0);
      check("post_rst_valid", spawn_valid, 0);

`ifdef SPAWN_JITTER_EN
      // Jittered reloads: level 0 with jitter 3 gives 53-tick spacing.
      jitter      = 2'd3;
      spawn_ready = 1'b1;
      do_start(4'd0, "jit_start");
      wait_rise(53, "jit_rise0");
      handshake(0, 6, "jit_hs0");
      wait_rise(53, "jit_rise1");
      handshake(1, 6, "jit_hs1");
      jitter = 2'd0;
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
